// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    function automatic int unsigned calc_src_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned calc_burst_w(input int unsigned max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int unsigned pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = int'(rr_ptr) + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: registered write, asynchronous read, extra-MSB pointers.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  push;
    logic                  pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Full/empty come from the current pointers, so a pop never frees room for a same-cycle push.
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst write arbiter merging NUM_REQ producers into one tagged FIFO.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    input  logic                          i_rd_en,
    output logic [DATA_WIDTH-1:0]         o_data_out,
    output logic [$clog2(NUM_REQ)-1:0]    o_src_id,
    output logic                          o_fifo_empty,
    output logic                          o_fifo_full
);

    localparam int unsigned SRC_W = calc_src_w(NUM_REQ);
    localparam int unsigned BW    = calc_burst_w(MAX_BURST);

    state_t                      state;
    logic [SRC_W-1:0]            rr_ptr;
    logic [SRC_W-1:0]            gnt_id;
    logic [BW-1:0]               burst_cnt;

    logic                        pick_valid;
    logic [SRC_W-1:0]            pick_idx;
    logic                        ack_en;
    logic                        gnt_req;
    logic                        gnt_last;
    logic [DATA_WIDTH-1:0]       gnt_data;
    logic                        burst_done;
    logic                        release_gnt;
    logic [SRC_W-1:0]            next_ptr;
    logic [SRC_W+DATA_WIDTH-1:0] fifo_rd_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr_pick (
        .req    (i_req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        gnt_req  = 1'b0;
        gnt_last = 1'b0;
        gnt_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == SRC_W'(k)) begin
                gnt_req  = i_req[k];
                gnt_last = i_req_last[k];
                gnt_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ack is combinational so an asynchronous reset drops it without a clock edge.
    assign ack_en = (state == GRANT) & gnt_req & ~o_fifo_full;

    always_comb begin
        o_ack = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == SRC_W'(k)) o_ack[k] = ack_en;
        end
    end

    assign burst_done  = (burst_cnt == BW'(MAX_BURST - 1));
    assign release_gnt = (state == GRANT) & (~gnt_req | (ack_en & (gnt_last | burst_done)));
    assign next_ptr    = (gnt_id == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_id    <= pick_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_gnt) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (ack_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DATA_WIDTH (SRC_W + DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (ack_en),
        .wr_data ({gnt_id, gnt_data}),
        .rd_en   (i_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (o_fifo_empty),
        .full    (o_fifo_full)
    );

    assign {o_src_id, o_data_out} = fifo_rd_data;

endmodule
